// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: schedules two single-port BRAM banks between one
// write engine and one read engine using start/busy job handshakes.
// Tracks per-bank fill state, launches jobs as soon as a bank qualifies,
// and steers each bank's address, data and write enable from bank ownership.
// Optional feature: define PINGPONG_STALL_CNT_EN to enable the writer stall
// counter on wr_stall_cnt; without it the port is tied to zero.
module pingpong_bank_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    // write engine
    output logic              wr_start,
    input  logic              wr_busy,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    // read engine
    output logic              rd_start,
    input  logic              rd_busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    // bank 0
    output logic              bank0_we,
    output logic [ADDR_W-1:0] bank0_addr,
    output logic [DATA_W-1:0] bank0_din,
    input  logic [DATA_W-1:0] bank0_dout,
    // bank 1
    output logic              bank1_we,
    output logic [ADDR_W-1:0] bank1_addr,
    output logic [DATA_W-1:0] bank1_din,
    input  logic [DATA_W-1:0] bank1_dout,
    // status
    output logic              wr_bank,
    output logic              rd_bank,
    output logic [1:0]        full_cnt,
    output logic [15:0]       wr_stall_cnt
);

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WRITING = 2'd1,
        ST_FULL    = 2'd2,
        ST_READING = 2'd3
    } bank_st_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_START = 2'd1,
        W_RUN   = 2'd2
    } wr_st_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_RUN   = 2'd2
    } rd_st_e;

    bank_st_e [1:0]   status_q, status_d;
    wr_st_e           w_state_q, w_state_d;
    rd_st_e           r_state_q, r_state_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             wr_start_q, wr_start_d;
    logic             rd_start_q, rd_start_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] full_cnt_q, full_cnt_d;
    logic             flush_req;
    logic             flush_exec;

    // A flush request is held until both engines are idle, then executes.
    assign flush_req  = flush | flush_pend_q;
    assign flush_exec = flush_req && (w_state_q == W_IDLE) && (r_state_q == R_IDLE);

    // Next-state logic for both job FSMs, bank status and pointers.
    always_comb begin
        status_d     = status_q;
        w_state_d    = w_state_q;
        r_state_d    = r_state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_start_d   = 1'b0;
        rd_start_d   = 1'b0;
        flush_pend_d = flush_req;

        if (flush_exec) begin
            // Both engines idle: only FREE or FULL banks exist here.
            flush_pend_d = 1'b0;
            if (status_q[0] == ST_FULL) status_d[0] = ST_FREE;
            if (status_q[1] == ST_FULL) status_d[1] = ST_FREE;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
        end else begin
            // Writer and reader always touch banks in different states,
            // so their status updates never collide on the same entry.
            unique case (w_state_q)
                W_IDLE: begin
                    if (en && (status_q[wr_bank_q] == ST_FREE)) begin
                        status_d[wr_bank_q] = ST_WRITING;
                        w_state_d           = W_START;
                        wr_start_d          = 1'b1;
                    end
                end
                W_START: begin
                    w_state_d = W_RUN;
                end
                W_RUN: begin
                    if (!wr_busy) begin
                        status_d[wr_bank_q] = ST_FULL;
                        wr_bank_d           = ~wr_bank_q;
                        w_state_d           = W_IDLE;
                    end
                end
                default: begin
                    w_state_d = W_IDLE;
                end
            endcase

            unique case (r_state_q)
                R_IDLE: begin
                    if (en && (status_q[rd_bank_q] == ST_FULL)) begin
                        status_d[rd_bank_q] = ST_READING;
                        r_state_d           = R_START;
                        rd_start_d          = 1'b1;
                    end
                end
                R_START: begin
                    r_state_d = R_RUN;
                end
                R_RUN: begin
                    if (!rd_busy) begin
                        status_d[rd_bank_q] = ST_FREE;
                        rd_bank_d           = ~rd_bank_q;
                        r_state_d           = R_IDLE;
                    end
                end
                default: begin
                    r_state_d = R_IDLE;
                end
            endcase
        end

        full_cnt_d = CNT_W'(status_d[0] == ST_FULL) + CNT_W'(status_d[1] == ST_FULL);
    end

    // State, pointer and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q     <= {ST_FREE, ST_FREE};
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_start_q   <= 1'b0;
            rd_start_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            full_cnt_q   <= '0;
        end else begin
            status_q     <= status_d;
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_start_q   <= wr_start_d;
            rd_start_q   <= rd_start_d;
            flush_pend_q <= flush_pend_d;
            full_cnt_q   <= full_cnt_d;
        end
    end

    assign wr_start = wr_start_q;
    assign rd_start = rd_start_q;
    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign full_cnt = full_cnt_q;

    // Bank steering: only the bank owned by the writer accepts writes.
    assign bank0_we   = wr_we & (status_q[0] == ST_WRITING);
    assign bank1_we   = wr_we & (status_q[1] == ST_WRITING);
    assign bank0_addr = (status_q[0] == ST_WRITING) ? wr_addr : rd_addr;
    assign bank1_addr = (status_q[1] == ST_WRITING) ? wr_addr : rd_addr;
    assign bank0_din  = wr_data;
    assign bank1_din  = wr_data;

    // Read data follows rd_bank, which holds until the read job is done.
    assign rd_data = rd_bank_q ? bank1_dout : bank0_dout;

`ifdef PINGPONG_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;
    logic               stall_cond;

    assign stall_cond = (w_state_q == W_IDLE) && en && (status_q[wr_bank_q] != ST_FREE);

    // Saturating count of cycles the writer wanted a bank but none was free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (flush_exec) begin
            stall_q <= '0;
        end else if (stall_cond && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign wr_stall_cnt = stall_q;
`else
    assign wr_stall_cnt = STALL_W'(0);
`endif

`ifndef SYNTHESIS
    // Ownership sanity: at most one bank is ever written.
    a_single_writer: assert property (@(posedge clk) disable iff (!rst_n)
        !((status_q[0] == ST_WRITING) && (status_q[1] == ST_WRITING)));
    a_single_we: assert property (@(posedge clk) disable iff (!rst_n)
        !(bank0_we && bank1_we));
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl: behavioural write/read engines and
// two BRAM models; expected values are hand-derived per cycle.
module tb_pingpong_bank_ctrl;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
`ifdef PINGPONG_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              flush;
    logic              wr_start;
    logic              wr_busy;
    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_start;
    logic              rd_busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              bank0_we, bank1_we;
    logic [ADDR_W-1:0] bank0_addr, bank1_addr;
    logic [DATA_W-1:0] bank0_din, bank1_din;
    logic [DATA_W-1:0] bank0_dout, bank1_dout;
    logic              wr_bank, rd_bank;
    logic [1:0]        full_cnt;
    logic [15:0]       wr_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int wr_len = 8;
    int rd_len = 8;
    int w_left = 0;
    int w_idx  = 0;
    int w_base = 0;
    int w_next = 0;
    int r_left = 0;
    int r_idx  = 0;
    bit r_cap  = 1'b0;
    logic [DATA_W-1:0] rd_log[$];

    logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    pingpong_bank_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .wr_start(wr_start), .wr_busy(wr_busy), .wr_we(wr_we),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_addr(rd_addr), .rd_data(rd_data),
        .bank0_we(bank0_we), .bank0_addr(bank0_addr), .bank0_din(bank0_din), .bank0_dout(bank0_dout),
        .bank1_we(bank1_we), .bank1_addr(bank1_addr), .bank1_din(bank1_din), .bank1_dout(bank1_dout),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .full_cnt(full_cnt), .wr_stall_cnt(wr_stall_cnt)
    );

    // Single-port BRAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (bank0_we) mem0[bank0_addr] <= bank0_din;
        bank0_dout <= mem0[bank0_addr];
        if (bank1_we) mem1[bank1_addr] <= bank1_din;
        bank1_dout <= mem1[bank1_addr];
    end

    // Write engine: busy from the cycle after wr_start, writes wr_len words.
    initial begin
        wr_busy = 1'b0; wr_we = 1'b0; wr_addr = '0; wr_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) w_left = 0;
            if (w_left != 0) begin
                wr_busy = 1'b1; wr_we = 1'b1;
                wr_addr = ADDR_W'(w_idx);
                wr_data = DATA_W'(w_base + w_idx);
                w_idx++; w_left--;
            end else begin
                wr_busy = 1'b0; wr_we = 1'b0;
            end
            if (wr_start && rst_n) begin
                w_left = wr_len; w_idx = 0; w_base = w_next; w_next += wr_len;
            end
        end
    end

    // Read engine: issues rd_len addresses, logs rd_data one cycle later.
    initial begin
        rd_busy = 1'b0; rd_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (r_cap) rd_log.push_back(rd_data);
            r_cap = 1'b0;
            if (!rst_n) r_left = 0;
            if (r_left != 0) begin
                rd_busy = 1'b1; rd_addr = ADDR_W'(r_idx);
                r_idx++; r_left--; r_cap = 1'b1;
            end else begin
                rd_busy = 1'b0;
            end
            if (rd_start && rst_n) begin
                r_left = rd_len; r_idx = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Cycle labels cN: negedge N cycles after reset release.
    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0;
        step(2);
        check_eq("rst_wr_start", 32'(wr_start), 32'd0);
        check_eq("rst_rd_start", 32'(rd_start), 32'd0);
        check_eq("rst_full_cnt", 32'(full_cnt), 32'd0);
        check_eq("rst_wr_bank", 32'(wr_bank), 32'd0);
        check_eq("rst_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("rst_bank0_we", 32'(bank0_we), 32'd0);
        check_eq("rst_bank1_we", 32'(bank1_we), 32'd0);
        check_eq("rst_stall", 32'(wr_stall_cnt), 32'd0);
        en = 1'b1;
        step(1);
        rst_n = 1'b1;                                           // c0
        check_eq("c0_wr_start", 32'(wr_start), 32'd0);
        step(1);                                                // c1
        check_eq("c1_wr_start", 32'(wr_start), 32'd1);
        check_eq("c1_rd_start", 32'(rd_start), 32'd0);
        step(1);                                                // c2
        check_eq("c2_wr_start", 32'(wr_start), 32'd0);
        check_eq("c2_bank0_we", 32'(bank0_we), 32'd1);
        check_eq("c2_bank1_we", 32'(bank1_we), 32'd0);
        step(8);                                                // c10
        check_eq("c10_full_cnt", 32'(full_cnt), 32'd0);
        step(1);                                                // c11
        check_eq("c11_full_cnt", 32'(full_cnt), 32'd1);
        check_eq("c11_wr_bank", 32'(wr_bank), 32'd1);
        check_eq("c11_rd_start", 32'(rd_start), 32'd0);
        step(1);                                                // c12
        check_eq("c12_wr_start", 32'(wr_start), 32'd1);
        check_eq("c12_rd_start", 32'(rd_start), 32'd1);
        check_eq("c12_full_cnt", 32'(full_cnt), 32'd0);
        step(1);                                                // c13
        check_eq("c13_bank1_we", 32'(bank1_we), 32'd1);
        check_eq("c13_bank0_we", 32'(bank0_we), 32'd0);
        step(9);                                                // c22
        check_eq("c22_full_cnt", 32'(full_cnt), 32'd1);
        check_eq("c22_wr_bank", 32'(wr_bank), 32'd0);
        check_eq("c22_rd_bank", 32'(rd_bank), 32'd1);
        step(1);                                                // c23
        check_eq("c23_wr_start", 32'(wr_start), 32'd1);
        check_eq("c23_rd_start", 32'(rd_start), 32'd1);
        en = 1'b0;
        step(10);                                               // c33
        check_eq("c33_full_cnt", 32'(full_cnt), 32'd1);
        check_eq("c33_wr_bank", 32'(wr_bank), 32'd1);
        check_eq("c33_rd_bank", 32'(rd_bank), 32'd0);
        step(1);                                                // c34
        check_eq("c34_wr_start", 32'(wr_start), 32'd0);
        check_eq("c34_rd_start", 32'(rd_start), 32'd0);
        check_eq("c34_stall", 32'(wr_stall_cnt), 32'd0);
        check_eq("rd_log_len", 32'(rd_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < rd_log.size(); i++)
            check_eq($sformatf("rd_word%0d", i), 32'(rd_log[i]), 32'(i));

        // Long read on bank0 while bank1 fills: writer stalls.
        en = 1'b1; wr_len = 2; rd_len = 30;
        step(1);                                                // c35
        check_eq("c35_wr_start", 32'(wr_start), 32'd1);
        check_eq("c35_rd_start", 32'(rd_start), 32'd1);
        step(15);                                               // c50
        check_eq("c50_full_cnt", 32'(full_cnt), 32'd1);
        check_eq("c50_wr_start", 32'(wr_start), 32'd0);
        check_eq("c50_stall", 32'(wr_stall_cnt), STALL_ON ? 32'd11 : 32'd0);
        step(17);                                               // c67
        check_eq("c67_full_cnt", 32'(full_cnt), 32'd1);
        check_eq("c67_stall", 32'(wr_stall_cnt), STALL_ON ? 32'd28 : 32'd0);
        en = 1'b0;
        step(1);                                                // c68
        check_eq("c68_wr_start", 32'(wr_start), 32'd0);
        check_eq("c68_stall", 32'(wr_stall_cnt), STALL_ON ? 32'd28 : 32'd0);

        // Flush requested while writer busy: deferred until both idle.
        en = 1'b1; wr_len = 6; rd_len = 0;
        step(1);                                                // c69
        check_eq("c69_wr_start", 32'(wr_start), 32'd1);
        check_eq("c69_rd_start", 32'(rd_start), 32'd1);
        en = 1'b0;
        step(2);                                                // c71
        check_eq("c71_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("c71_full_cnt", 32'(full_cnt), 32'd0);
        step(1);                                                // c72
        flush = 1'b1;
        step(1);                                                // c73
        flush = 1'b0;
        step(4);                                                // c77
        check_eq("c77_full_cnt", 32'(full_cnt), 32'd1);
        check_eq("c77_wr_bank", 32'(wr_bank), 32'd1);
        check_eq("c77_stall", 32'(wr_stall_cnt), STALL_ON ? 32'd28 : 32'd0);
        step(1);                                                // c78
        check_eq("c78_full_cnt", 32'(full_cnt), 32'd0);
        check_eq("c78_wr_bank", 32'(wr_bank), 32'd0);
        check_eq("c78_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("c78_stall", 32'(wr_stall_cnt), 32'd0);

        // Reset in the middle of a write job.
        en = 1'b1; wr_len = 10;
        step(1);                                                // c79
        check_eq("c79_wr_start", 32'(wr_start), 32'd1);
        step(3);                                                // c82
        check_eq("c82_bank0_we", 32'(bank0_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_bank0_we", 32'(bank0_we), 32'd0);
        check_eq("mid_rst_wr_start", 32'(wr_start), 32'd0);
        check_eq("mid_rst_full_cnt", 32'(full_cnt), 32'd0);
        check_eq("mid_rst_wr_bank", 32'(wr_bank), 32'd0);
        step(2);                                                // c84
        rst_n = 1'b1;
        step(1);                                                // c85
        check_eq("post_rst_wr_start", 32'(wr_start), 32'd1);
        check_eq("post_rst_wr_bank", 32'(wr_bank), 32'd0);
        en = 1'b0;
        step(1);                                                // c86
        check_eq("post_rst_bank0_we", 32'(bank0_we), 32'd1);
        check_eq("post_rst_bank1_we", 32'(bank1_we), 32'd0);
        step(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
